// File: rtl/stream_demux_1_n_if.sv
// stream_demux_1_n_if: valid/ready bundle between one source and CHANNELS consumers.
interface stream_demux_1_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int ERR_W    = 8
);
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [ERR_W-1:0]          err_cnt;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_cnt
    );
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_cnt
    );
endinterface

// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: routes or broadcasts a valid/ready stream into per-channel one-entry holding registers.
module stream_demux_1_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int ERR_W    = 8
) (
    input logic               clk,
    input logic               rst_n,
    stream_demux_1_n_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e                             state_q [CHANNELS];
    state_e                             state_d [CHANNELS];
    logic   [CHANNELS-1:0][WIDTH-1:0]   data_q, data_d;
    logic   [CHANNELS-1:0]              free, hit, load;
    logic   [ERR_W-1:0]                 err_q, err_d;
    logic                               sel_ok, xfer;

    always_comb begin
        sel_ok = 32'(bus.in_sel) < CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
            free[k] = (state_q[k] == EMPTY) | bus.out_ready[k];
            hit[k]  = 32'(bus.in_sel) == k;
        end
        // an invalid select is always accepted so the source never deadlocks on it
        bus.in_ready = bus.in_bcast ? &free : (!sel_ok || |(free & hit));
        xfer = bus.in_valid & bus.in_ready;
        for (int k = 0; k < CHANNELS; k++) begin
            load[k]       = xfer & (bus.in_bcast | hit[k]);
            state_d[k]    = load[k] ? FULL : (bus.out_ready[k] ? EMPTY : state_q[k]);
            data_d[k]     = load[k] ? bus.in_data : data_q[k];
            bus.out_valid[k] = state_q[k] == FULL;
        end
        err_d = (xfer && !bus.in_bcast && !sel_ok && !(&err_q)) ? err_q + 1'b1 : err_q;
        bus.out_data = data_q;
        bus.err_cnt  = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) state_q[k] <= EMPTY;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) state_q[k] <= state_d[k];
            data_q <= data_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_stream_demux_1_n.sv
// tb_stream_demux_1_n: directed vector table plus corner sequences and a scoreboarded random run.
module tb_stream_demux_1_n;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stream_demux_1_n_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .ERR_W(8)) a ();
    stream_demux_1_n_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .ERR_W(2)) b ();

    stream_demux_1_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .ERR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    stream_demux_1_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .ERR_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct {
        logic        v;
        logic        bc;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  rdy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs [13];
    logic [7:0] q [4][$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic bc, input logic [1:0] sel, input logic [7:0] d, input logic [3:0] rdy);
        a.in_valid = v; a.in_bcast = bc; a.in_sel = sel; a.in_data = d; a.out_ready = rdy;
    endtask

    task automatic drive_b(input logic v, input logic bc, input logic [1:0] sel, input logic [7:0] d, input logic [2:0] rdy);
        b.in_valid = v; b.in_bcast = bc; b.in_sel = sel; b.in_data = d; b.out_ready = rdy;
    endtask

    initial begin
        //            v     bc    sel   data   ready    ir    ov       out_data
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 32'h00A50000};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'h3C, 4'b1111, 1'b1, 4'b0001, 32'h00A5003C};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00A5003C};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0010, 32'h00A5113C};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 32'h00A5113C};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h00A5223C};
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00A5223C};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 8'h77, 4'b1011, 1'b1, 4'b0100, 32'h0077223C};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'b1011, 1'b0, 4'b0100, 32'h0077223C};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'b1111, 1'b1, 4'b1111, 32'hFFFFFFFF};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1111, 32'hFFFFFFFF};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 8'h99, 4'b0000, 1'b0, 4'b1111, 32'hFFFFFFFF};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 8'h12, 4'b1111, 1'b1, 4'b0000, 32'hFFFFFFFF};

        drive_a(0, 0, 0, 0, 4'b1111);
        drive_b(0, 0, 0, 0, 3'b111);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("reset_ov", a.out_valid, 4'b0000);
        chk("reset_od", a.out_data, 32'h0);
        chk("reset_err", a.err_cnt, 8'h0);
        chk("reset_ir", a.in_ready, 1'b1);
        step();

        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i].v, vecs[i].bc, vecs[i].sel, vecs[i].d, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_ir", i), a.in_ready, vecs[i].exp_ir);
            step();
            chk($sformatf("vec%0d_ov", i), a.out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_od", i), a.out_data, vecs[i].exp_od);
        end
        chk("a_err_zero", a.err_cnt, 8'h0);

        // invalid select on a 3-channel instance, counter saturating at 3
        drive_b(0, 0, 2'd3, 8'h44, 3'b111);
        step();
        chk("b_idle_err", b.err_cnt, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            drive_b(1, 0, 2'd3, 8'h40 + 8'(i), 3'b111);
            #1;
            chk($sformatf("b_inv%0d_ir", i), b.in_ready, 1'b1);
            step();
            chk($sformatf("b_inv%0d_err", i), b.err_cnt, (i < 3) ? 2'(i) : 2'd3);
            chk($sformatf("b_inv%0d_ov", i), b.out_valid, 3'b000);
        end
        drive_b(1, 1, 2'd3, 8'hC3, 3'b111);
        step();
        chk("b_bcast_ov", b.out_valid, 3'b111);
        chk("b_bcast_od", b.out_data, 24'hC3C3C3);
        chk("b_bcast_err", b.err_cnt, 2'd3);
        drive_b(0, 0, 0, 0, 3'b000);

        // asynchronous reset mid-operation
        drive_a(1, 0, 2'd0, 8'h10, 4'b0000);
        step();
        drive_a(1, 0, 2'd3, 8'h30, 4'b0000);
        step();
        chk("pre_rst_ov", a.out_valid, 4'b1001);
        drive_a(0, 0, 0, 0, 4'b0000);
        rst_n = 0;
        #1;
        chk("async_rst_ov", a.out_valid, 4'b0000);
        chk("async_rst_od", a.out_data, 32'h0);
        chk("async_rst_b_err", b.err_cnt, 2'd0);
        chk("async_rst_b_ov", b.out_valid, 3'b000);
        #1 rst_n = 1;
        step();
        drive_a(1, 0, 2'd3, 8'h5A, 4'b0000);
        #1;
        chk("post_rst_ir", a.in_ready, 1'b1);
        step();
        chk("post_rst_ov", a.out_valid, 4'b1000);
        chk("post_rst_od", a.out_data, 32'h5A000000);
        drive_a(0, 0, 0, 0, 4'b1111);
        step();
        chk("drain_ov", a.out_valid, 4'b0000);

        // random traffic against a per-channel FIFO scoreboard
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] fr;
            logic       er;
            drive_a(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                    8'($urandom), 4'($urandom));
            #1;
            for (int k = 0; k < 4; k++) fr[k] = (q[k].size() == 0) || a.out_ready[k];
            er = a.in_bcast ? &fr : fr[a.in_sel];
            chk("rnd_ir", a.in_ready, er);
            for (int k = 0; k < 4; k++) begin
                chk("rnd_ov", a.out_valid[k], q[k].size() != 0);
                if (q[k].size() != 0 && a.out_ready[k])
                    chk("rnd_data", a.out_data[k*8 +: 8], q[k].pop_front());
            end
            if (a.in_valid && er)
                for (int k = 0; k < 4; k++)
                    if (a.in_bcast || a.in_sel == 2'(k)) q[k].push_back(a.in_data);
            step();
        end
        for (int k = 0; k < 4; k++) chk("rnd_end_ov", a.out_valid[k], q[k].size() != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
